// File: rtl/ahb_cfg_master_pkg.sv
// Types local to the AHB configuration-port initiator.
package ahb_cfg_master_pkg;

  // Data-phase tracking: only direction is needed once the address has been taken.
  typedef struct packed {
    logic valid;
    logic write;
  } dp_t;

  localparam dp_t DP_EMPTY = '{valid: 1'b0, write: 1'b0};

endpackage

// File: rtl/ahb_enum.sv
// Shared AHB encoding constants used by every AHB master/slave in the codebase.
package ahb_enum;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [1:0] AHB_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AHB_RESP_ERROR   = 2'b01;
  localparam logic [1:0] AHB_RESP_RETRY   = 2'b10;
  localparam logic [1:0] AHB_RESP_SPLIT   = 2'b11;

  localparam logic [2:0] AHB_BURST_SINGLE = 3'b000;
  localparam logic [2:0] AHB_SIZE_WORD    = 3'b010;

  localparam logic [3:0] AHB_PROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/ahb_cfg_master.sv
// Single-transfer AHB initiator: valid/ready command stream in, pipelined NONSEQ/SINGLE
// transfers out, one response per command with read data and error status.
module ahb_cfg_master
  import ahb_enum::*;
  import ahb_cfg_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     hsel,
  output logic [ADDR_WIDTH-1:0]    haddr,
  output logic [3:0]               hprot,
  output logic [2:0]               hsize,
  output logic [1:0]               htrans,
  output logic [2:0]               hburst,
  output logic                     hwrite,
  output logic [DATA_WIDTH-1:0]    hwdata,
  input  logic [1:0]               hresp,
  input  logic                     hgrant,
  input  logic                     hready,
  input  logic [DATA_WIDTH-1:0]    hrdata
);

  logic                  ap_valid;
  logic                  ap_write;
  logic [ADDR_WIDTH-1:0] ap_addr;
  logic [DATA_WIDTH-1:0] ap_wdata;
  dp_t                   dp;
  logic                  err_hold;

  logic ap_issue_c;
  logic ap_accept_c;
  logic req_fire_c;
  logic dp_done_c;
  logic resp_err_c;

  // Address phase is driven only when owned and not in the second ERROR cycle.
  assign ap_issue_c  = ap_valid & ~err_hold & hgrant;
  assign ap_accept_c = ap_issue_c & hready;
  assign req_ready   = ~ap_valid | ap_accept_c;
  assign req_fire_c  = req_valid & req_ready;
  assign dp_done_c   = dp.valid & hready;
  assign resp_err_c  = (hresp == AHB_RESP_ERROR);

  assign htrans = ap_issue_c ? AHB_TRANS_NONSEQ : AHB_TRANS_IDLE;
  assign hsel   = ap_issue_c;
  assign haddr  = ap_addr;
  assign hwrite = ap_write;
  assign hprot  = AHB_PROT_DATA_PRIV;
  assign hsize  = AHB_SIZE_WORD;
  assign hburst = AHB_BURST_SINGLE;
  assign busy   = ap_valid | dp.valid | rsp_valid;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_valid  <= 1'b0;
      ap_write  <= 1'b0;
      ap_addr   <= '0;
      ap_wdata  <= '0;
      dp        <= DP_EMPTY;
      err_hold  <= 1'b0;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // A new command can only land when the slot empties this cycle or was empty.
      if (req_fire_c) begin
        ap_valid <= 1'b1;
        ap_write <= req_write;
        ap_addr  <= req_addr;
        ap_wdata <= req_wdata;
      end else if (ap_accept_c) begin
        ap_valid <= 1'b0;
      end

      if (ap_accept_c) begin
        dp     <= '{valid: 1'b1, write: ap_write};
        hwdata <= ap_wdata;
      end else if (dp_done_c) begin
        dp.valid <= 1'b0;
      end

      // Set in the first ERROR cycle; blocks issue through the second.
      if (dp.valid && resp_err_c && !hready) begin
        err_hold <= 1'b1;
      end else if (hready) begin
        err_hold <= 1'b0;
      end

      rsp_valid <= dp_done_c;
      rsp_rdata <= (dp_done_c && !dp.write) ? hrdata : '0;
      rsp_err   <= dp_done_c & resp_err_c;

      if (dp_done_c && resp_err_c && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_cfg_master.sv
// Bench for ahb_cfg_master: behavioural AHB slave with wait/error injection and an
// in-order response scoreboard, plus directed bus-timing checks.
module tb_ahb_cfg_master;
  import ahb_enum::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [CW-1:0] err_cnt;
  logic          hsel, hwrite, hgrant, hready;
  logic [AW-1:0] haddr;
  logic [3:0]    hprot;
  logic [2:0]    hsize, hburst;
  logic [1:0]    htrans, hresp;
  logic [DW-1:0] hwdata, hrdata;

  ahb_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .err_cnt(err_cnt),
    .hsel(hsel), .haddr(haddr), .hprot(hprot), .hsize(hsize), .htrans(htrans),
    .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata),
    .hresp(hresp), .hgrant(hgrant), .hready(hready), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave model: per-transfer wait states or two-cycle ERROR chosen by address.
  logic [31:0] wait_addr, err_addr;
  int          wait_n;
  logic        s_act, s_wr, s_err, s_err2;
  logic [31:0] s_addr;
  int          s_ws;
  logic [31:0] smem [256] = '{default: '0};

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_err2 <= 1'b0;
      s_addr <= '0; s_ws <= 0;
    end else if (hready) begin
      if (s_act && s_wr && !s_err) smem[s_addr[9:2]] <= hwdata;
      s_act  <= (htrans == AHB_TRANS_NONSEQ);
      s_addr <= haddr;
      s_wr   <= hwrite;
      s_ws   <= (haddr == wait_addr) ? wait_n : 0;
      s_err  <= (haddr == err_addr);
      s_err2 <= 1'b0;
    end else if (s_ws != 0) begin
      s_ws <= s_ws - 1;
    end else if (s_err) begin
      s_err2 <= 1'b1;
    end
  end

  assign hready = !s_act ? 1'b1 : (s_ws != 0) ? 1'b0 : s_err ? s_err2 : 1'b1;
  assign hresp  = (s_act && s_ws == 0 && s_err) ? AHB_RESP_ERROR : AHB_RESP_OKAY;
  assign hrdata = s_act ? smem[s_addr[9:2]] : '0;

  // Scoreboard: expectation pushed at command acceptance, popped at rsp_valid.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256] = '{default: '0};
  int          cmd_cnt = 0;
  int          rsp_cnt = 0;

  always @(posedge hclk) begin
    if (hresetn && req_valid && req_ready) begin
      exp_t e;
      e.err   = req_write && (req_addr == err_addr);
      e.rdata = req_write ? 32'h0 : ref_mem[req_addr[9:2]];
      if (req_write && !e.err) ref_mem[req_addr[9:2]] = req_wdata;
      exp_q.push_back(e);
      cmd_cnt++;
    end
  end

  always @(negedge hclk) begin
    if (hresetn && rsp_valid) begin
      rsp_cnt++;
      check("rsp_has_exp", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic check_reset_outs();
    check("rst_htrans", 32'(htrans), 32'(AHB_TRANS_IDLE));
    check("rst_hsel", 32'(hsel), 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_hwrite", 32'(hwrite), 32'd0);
    check("rst_hwdata", hwdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Present a command at a falling edge and hold until the next rising edge takes it.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge hclk); #1;
      n++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    @(negedge hclk);
  endtask

  logic [7:0] ns_v, rsp_v, rdy_v;
  int         held, rsp_seen;
  logic       saw_err2, reissued;

  initial begin
    hresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    hgrant = 1'b1; wait_addr = 32'hFFFF_FFFF; wait_n = 0; err_addr = 32'h200;
    repeat (2) @(negedge hclk);
    check_reset_outs();
    hresetn = 1'b1;
    @(negedge hclk);

    // Single write, then read-back
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h2000_0000;
    check("wr_ready", 32'(req_ready), 32'd1);
    @(negedge hclk);
    req_valid = 1'b0;
    check("wr_htrans", 32'(htrans), 32'(AHB_TRANS_NONSEQ));
    check("wr_haddr", haddr, 32'h10);
    check("wr_hwrite", 32'(hwrite), 32'd1);
    check("wr_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge hclk);
    check("wr_hwdata", hwdata, 32'h2000_0000);
    check("wr_rsp_dp", 32'(rsp_valid), 32'd0);
    @(negedge hclk);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_err", 32'(rsp_err), 32'd0);

    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(negedge hclk);
    req_valid = 1'b0;
    repeat (2) @(negedge hclk);
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h2000_0000);
    repeat (2) @(negedge hclk);

    // Four back-to-back writes with req_valid held high
    ns_v = '0; rsp_v = '0; rdy_v = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 32'h10 + 32'(4 * k); req_wdata = 32'hA0 + 32'(k);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      ns_v[k]  = (htrans == AHB_TRANS_NONSEQ);
      rsp_v[k] = rsp_valid;
      rdy_v[k] = req_ready;
      @(negedge hclk);
    end
    check("b2b_nonseq", 32'(ns_v), 32'h1E);
    check("b2b_rsp", 32'(rsp_v), 32'h78);
    check("b2b_ready", 32'(rdy_v[3:0]), 32'hF);

    // Three wait states on the second of two reads, third command queued
    wait_addr = 32'h14; wait_n = 3;
    issue(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h14, 32'h0);
    issue(1'b0, 32'h18, 32'h0);
    req_valid = 1'b0;
    held = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (htrans == AHB_TRANS_NONSEQ && haddr == 32'h18 && !hready) held++;
      @(negedge hclk);
    end
    check("ws_held", 32'(held), 32'd3);
    check("ws_rsp_count", 32'(rsp_cnt), 32'(cmd_cnt));
    wait_addr = 32'hFFFF_FFFF;

    // Two-cycle ERROR on a write with a read pending in the address phase
    issue(1'b1, 32'h200, 32'hDEAD_BEEF);
    issue(1'b0, 32'h14, 32'h0);
    req_valid = 1'b0;
    saw_err2 = 1'b0; reissued = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (hresp == AHB_RESP_ERROR && hready) begin
        saw_err2 = 1'b1;
        check("err2_htrans", 32'(htrans), 32'(AHB_TRANS_IDLE));
      end else if (saw_err2 && htrans == AHB_TRANS_NONSEQ && haddr == 32'h14) begin
        reissued = 1'b1;
      end
      @(negedge hclk);
    end
    check("err_seen", 32'(saw_err2), 32'd1);
    check("err_reissue", 32'(reissued), 32'd1);
    check("err_cnt", 32'(err_cnt), 32'd1);
    check("err_rsp_count", 32'(rsp_cnt), 32'(cmd_cnt));

    // Grant withheld with a command pending, then reset in the data phase
    wait_addr = 32'h18; wait_n = 3;
    hgrant = 1'b0;
    issue(1'b0, 32'h18, 32'h0);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("nogrant_htrans", 32'(htrans), 32'(AHB_TRANS_IDLE));
      check("nogrant_busy", 32'(busy), 32'd1);
      @(negedge hclk);
    end
    hgrant = 1'b1;
    #1;
    check("grant_htrans", 32'(htrans), 32'(AHB_TRANS_NONSEQ));
    check("grant_haddr", haddr, 32'h18);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outs();
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge hclk); #1;
      if (rsp_valid) rsp_seen++;
    end
    check("post_rst_rsp", 32'(rsp_seen), 32'd0);
    check("post_rst_htrans", 32'(htrans), 32'(AHB_TRANS_IDLE));
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_cfg_master.md
Name: ahb_cfg_master

Overview:
- Single-transfer AHB initiator that drives an AHB configuration slave port, such as the IOPMP config port or any peripheral register bank.
- Converts a simple valid/ready command stream (firmware sequencer, boot loader, debug bridge) into pipelined AHB NONSEQ/SINGLE transfers.
- Returns one response per command, carrying read data and error status.
- Address phase of command N+1 overlaps data phase of command N; full hready, hgrant and two-cycle ERROR handling.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, AHB data width and command/response data width
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
hclk  input  1  clock
hresetn  input  1  reset, asynchronous, active-low
req_valid  input  1  command valid
req_ready  output  1  command accepted when req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  target byte address (word aligned)
req_wdata  input  DATA_WIDTH  write data (ignored for reads)
rsp_valid  output  1  one-cycle response pulse, no backpressure
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  transfer ended with ERROR response
busy  output  1  any command in address phase, data phase or response stage
err_cnt  output  ERR_CNT_WIDTH  saturating count of ERROR responses
hsel  output  1  = (htrans != IDLE)
haddr  output  ADDR_WIDTH  address-phase address
hprot  output  4  constant 4'b0011 (data, privileged)
hsize  output  3  constant WORD
htrans  output  2  IDLE or NONSEQ only
hburst  output  3  constant SINGLE
hwrite  output  1  address-phase direction
hwdata  output  DATA_WIDTH  data-phase write data, registered
hresp  input  2  slave response
hgrant  input  1  bus ownership
hready  input  1  transfer done / bus ready
hrdata  input  DATA_WIDTH  read data

Behaviour:
- State: address-phase register AP (valid, write, addr, wdata); data-phase register DP (valid, write); err_hold flag; response register.
- Reset values:
  - htrans IDLE; hsel 0; haddr 0; hwrite 0; hwdata 0.
  - rsp_valid 0; rsp_rdata 0; rsp_err 0; busy 0; err_cnt 0.
  - AP, DP and err_hold cleared.
- htrans = NONSEQ when AP.valid & !err_hold & hgrant, else IDLE. haddr/hwrite always show AP contents.
- ap_accept = AP.valid & !err_hold & hgrant & hready.
  - On ap_accept: DP <= AP, hwdata <= AP.wdata.
  - AP loads the next command if one is accepted in the same cycle, else AP.valid <= 0.
- req_ready = !AP.valid | ap_accept. A command accepted with AP empty appears on the bus the next cycle (1-cycle issue latency).
- Back-to-back: a new address phase every cycle while hready=1 and hgrant=1.
- Data phase completes when DP.valid & hready. The next cycle produces rsp_valid=1 with:
  - rsp_rdata = read ? hrdata : 0
  - rsp_err = (hresp == ERROR)
  - DP.valid cleared unless refilled by ap_accept.
  - Response latency: 2 cycles after address-phase acceptance with zero wait states.
- Wait states (hready=0): AP, DP and hwdata hold; no response.
- ERROR, first cycle (DP.valid & hresp==ERROR & !hready): set err_hold.
  - During the second cycle htrans is IDLE, so the pending AP is not accepted; it is not dropped.
  - err_hold clears when hready=1; the pending AP is re-presented as NONSEQ the following cycle.
- err_cnt increments once per ERROR-completed transfer and saturates at all-ones.
- hgrant=0: htrans IDLE and AP holds. An in-flight data phase still completes normally.
- busy = AP.valid | DP.valid | rsp_valid.
- Reset mid-operation: all state is discarded immediately; no response is produced for in-flight commands.
- Never issues SEQ/BUSY; never issues a transfer while err_hold is set.

Decomposition:
- Use AHB_TRANS_*, AHB_RESP_*, AHB_BURST_SINGLE and AHB_SIZE_WORD from the shared ahb_enum package; add any that are missing there.
- No sub-module; single always_ff plus combinational htrans/req_ready/accept logic.

Test Plan:
- Write 0x10 = 0x2000_0000 to an always-ready slave. Required: NONSEQ at 0x10 one cycle after acceptance, hwdata 0x2000_0000 next cycle, rsp_valid with rsp_err=0 two cycles after acceptance.
- Read 0x10 after that write (slave returns 0x2000_0000). Required: rsp_rdata=0x2000_0000, rsp_err=0.
- Four back-to-back writes, 0x10..0x1C, with req_valid held high. Required: four consecutive NONSEQ cycles, four consecutive rsp_valid pulses, req_ready stays 1.
- Slave inserts 3 wait states on the second of two reads. Required: haddr of the third command held for 3 cycles, responses in order, no duplicate rsp_valid.
- Two-cycle ERROR on a write at 0x200 with a read to 0x14 pending in AP. Required: htrans IDLE in the second ERROR cycle, rsp_err=1, err_cnt=1, then the read to 0x14 re-issued as NONSEQ and completing OK.
- hgrant low for 5 cycles with a command pending, then hresetn pulsed mid data phase. Required: htrans IDLE while hgrant=0; after reset, all outputs at reset values and no rsp_valid.
